// File: rtl/upsample_unpool_engine.sv
// upsample_unpool_engine: expands a pooled map read from a source SRAM over
// per-element stride windows and writes the full map into a destination SRAM.
// Ports: clk, rst (async, active-high); start/busy/done job handshake;
// src_rd_en/src_addr/src_rd_data source read port (1-cycle read latency);
// dst_wr_en/dst_addr/dst_wr_data destination write port.
// Macro ZERO_FILL_EN: max-unpool mode, only the window anchor gets data.
module upsample_unpool_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int IN_ROWS     = 4,
    parameter int IN_COLS     = 3,
    parameter int STRIDE_ROWS = 3,
    parameter int STRIDE_COLS = 4,
    parameter int OUT_ROWS    = 10,
    parameter int OUT_COLS    = 10,
    localparam int SA_W = $clog2(IN_ROWS * IN_COLS),
    localparam int DA_W = $clog2(OUT_ROWS * OUT_COLS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  src_rd_en,
    output logic [SA_W-1:0]       src_addr,
    input  logic [DATA_WIDTH-1:0] src_rd_data,
    output logic                  dst_wr_en,
    output logic [DA_W-1:0]       dst_addr,
    output logic [DATA_WIDTH-1:0] dst_wr_data
);

    localparam int AW = DA_W + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    generate
        if (STRIDE_ROWS < 1 || STRIDE_COLS < 1 ||
            OUT_ROWS <= (IN_ROWS - 1) * STRIDE_ROWS ||
            OUT_ROWS >  IN_ROWS * STRIDE_ROWS ||
            OUT_COLS <= (IN_COLS - 1) * STRIDE_COLS ||
            OUT_COLS >  IN_COLS * STRIDE_COLS) begin : g_bad_cfg
            $error("upsample_unpool_engine: illegal stride/size combination");
        end
    endgenerate

    logic [2:0]            state_q, state_d;
    logic [AW-1:0]         r_q, r_d, c_q, c_d;
    logic [AW-1:0]         dy_q, dy_d, dx_q, dx_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    logic [AW-1:0]         y0, x0, rem_r, rem_c, h, w;
    logic [AW-1:0]         src_lin, dst_lin;
    logic                  last_dx, last_dy, last_elem;
    logic [DATA_WIDTH-1:0] wr_val;

    // Window geometry; bottom/right windows clip against the output edge.
    always_comb begin
        y0        = r_q * AW'(STRIDE_ROWS);
        x0        = c_q * AW'(STRIDE_COLS);
        rem_r     = AW'(OUT_ROWS) - y0;
        rem_c     = AW'(OUT_COLS) - x0;
        h         = (rem_r < AW'(STRIDE_ROWS)) ? rem_r : AW'(STRIDE_ROWS);
        w         = (rem_c < AW'(STRIDE_COLS)) ? rem_c : AW'(STRIDE_COLS);
        src_lin   = r_q * AW'(IN_COLS) + c_q;
        dst_lin   = (y0 + dy_q) * AW'(OUT_COLS) + x0 + dx_q;
        last_dx   = (dx_q == w - AW'(1));
        last_dy   = (dy_q == h - AW'(1));
        last_elem = (r_q == AW'(IN_ROWS - 1)) && (c_q == AW'(IN_COLS - 1));
`ifdef ZERO_FILL_EN
        wr_val    = (dy_q == '0 && dx_q == '0) ? hold_q : '0;
`else
        wr_val    = hold_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        dy_d    = dy_q;
        dx_d    = dx_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD;
                    r_d     = '0;
                    c_d     = '0;
                    dy_d    = '0;
                    dx_d    = '0;
                end
            end
            S_RD: state_d = S_WAIT;
            S_WAIT: begin
                // Read data is valid this cycle; capture it for the window.
                state_d = S_WR;
                hold_d  = src_rd_data;
                dy_d    = '0;
                dx_d    = '0;
            end
            S_WR: begin
                if (!last_dx) begin
                    dx_d = dx_q + AW'(1);
                end else if (!last_dy) begin
                    dx_d = '0;
                    dy_d = dy_q + AW'(1);
                end else begin
                    dx_d = '0;
                    dy_d = '0;
                    if (last_elem) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                        if (c_q == AW'(IN_COLS - 1)) begin
                            c_d = '0;
                            r_d = r_q + AW'(1);
                        end else begin
                            c_d = c_q + AW'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                r_d     = '0;
                c_d     = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
            dy_q    <= '0;
            dx_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            dy_q    <= dy_d;
            dx_q    <= dx_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs decode straight from state so reset clears them immediately.
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign src_rd_en   = (state_q == S_RD);
    assign dst_wr_en   = (state_q == S_WR);
    assign src_addr    = src_rd_en ? SA_W'(src_lin) : '0;
    assign dst_addr    = dst_wr_en ? DA_W'(dst_lin) : '0;
    assign dst_wr_data = dst_wr_en ? wr_val : '0;

endmodule

// File: tb/tb_upsample_unpool_engine.sv
// tb_upsample_unpool_engine: random-data bench for upsample_unpool_engine
// against a coordinate-division reference model and SRAM write monitors.
module tb_upsample_unpool_engine;

    localparam int DW = 8;
    localparam int IR = 4, IC = 3, SR = 3, SC = 4, OR = 10, OC = 10;
    localparam int NI = IR * IC;
    localparam int NO = OR * OC;
    localparam int SA_W = $clog2(NI);
    localparam int DA_W = $clog2(NO);
    localparam int JOB_CYC = 2 * NI + NO + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy, done;
    logic            src_rd_en, dst_wr_en;
    logic [SA_W-1:0] src_addr;
    logic [DA_W-1:0] dst_addr;
    logic [DW-1:0]   src_rd_data;
    logic [DW-1:0]   dst_wr_data;

    always #5 clk = ~clk;

    upsample_unpool_engine #(
        .DATA_WIDTH(DW), .IN_ROWS(IR), .IN_COLS(IC),
        .STRIDE_ROWS(SR), .STRIDE_COLS(SC),
        .OUT_ROWS(OR), .OUT_COLS(OC)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done),
        .src_rd_en(src_rd_en), .src_addr(src_addr),
        .src_rd_data(src_rd_data),
        .dst_wr_en(dst_wr_en), .dst_addr(dst_addr),
        .dst_wr_data(dst_wr_data)
    );

    // Straight-copy geometry: 4x4 in, stride 1, 4x4 out.
    logic       start2, busy2, done2, rd2, wr2;
    logic [3:0] sa2, da2;
    logic [7:0] rdd2, wd2;
    logic [7:0] src2 [16];
    logic [7:0] dst2 [16];
    int         wr2_cnt = 0;

    upsample_unpool_engine #(
        .DATA_WIDTH(8), .IN_ROWS(4), .IN_COLS(4),
        .STRIDE_ROWS(1), .STRIDE_COLS(1),
        .OUT_ROWS(4), .OUT_COLS(4)
    ) u_copy (
        .clk(clk), .rst(rst), .start(start2),
        .busy(busy2), .done(done2),
        .src_rd_en(rd2), .src_addr(sa2), .src_rd_data(rdd2),
        .dst_wr_en(wr2), .dst_addr(da2), .dst_wr_data(wd2)
    );

    always @(posedge clk) begin
        if (rd2) rdd2 <= src2[sa2];
        if (wr2) begin
            dst2[da2] <= wd2;
            wr2_cnt   <= wr2_cnt + 1;
        end
    end

    logic [DW-1:0] src_mem [NI];
    logic [DW-1:0] dst_mem [NO];
    int  hits [NO];
    int  rd_cnt, wr_cnt, both_cnt, oob_cnt, done_cnt;
    logic clr = 1'b0;

    always @(posedge clk) begin
        if (clr) begin
            rd_cnt   <= 0;
            wr_cnt   <= 0;
            both_cnt <= 0;
            oob_cnt  <= 0;
            done_cnt <= 0;
            for (int i = 0; i < NO; i++) hits[i] <= 0;
        end else begin
            if (src_rd_en) begin
                rd_cnt <= rd_cnt + 1;
                if (int'(src_addr) < NI) src_rd_data <= src_mem[src_addr];
                else oob_cnt <= oob_cnt + 1;
            end
            if (dst_wr_en) begin
                wr_cnt <= wr_cnt + 1;
                if (int'(dst_addr) < NO) begin
                    dst_mem[dst_addr] <= dst_wr_data;
                    hits[dst_addr]    <= hits[dst_addr] + 1;
                end else begin
                    oob_cnt <= oob_cnt + 1;
                end
            end
            if (src_rd_en && dst_wr_en) both_cnt <= both_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Each output cell maps back to its source element by integer division.
    function automatic logic [DW-1:0] model(input int y, input int x);
        logic [DW-1:0] v;
        v = src_mem[(y / SR) * IC + (x / SC)];
`ifdef ZERO_FILL_EN
        if ((y % SR) != 0 || (x % SC) != 0) v = '0;
`endif
        return v;
    endfunction

    task automatic run_job(input int restart_at, input int rst_at,
                           output int cyc);
        bit fin;
        int w_at_rst;
        @(negedge clk);
        clr   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        clr   = 1'b0;
        start = 1'b0;
        cyc   = 0;
        fin   = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_outputs_zero",
                      {busy, done, src_rd_en, dst_wr_en,
                       src_addr, dst_addr, dst_wr_data}, 0);
                w_at_rst = wr_cnt;
                @(negedge clk);
                rst = 1'b0;
                repeat (6) @(negedge clk);
                check("rst_no_more_writes", wr_cnt, w_at_rst);
                check("rst_idle", busy, 0);
                fin = 1'b1;
            end else if (done) begin
                // start during the done cycle must not launch a new job
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                check("done_start_ignored", busy, 0);
                repeat (2) @(negedge clk);
                check("still_idle", busy, 0);
                fin = 1'b1;
            end else if (cyc > 4 * JOB_CYC) begin
                check("timeout_done", cyc, JOB_CYC);
                fin = 1'b1;
            end
        end
    endtask

    task automatic verify_job(input string tag, input int cyc);
        int bad_hits;
        check({tag, "_cycles"}, cyc, JOB_CYC);
        check({tag, "_rd_cnt"}, rd_cnt, NI);
        check({tag, "_wr_cnt"}, wr_cnt, NO);
        check({tag, "_rd_wr_overlap"}, both_cnt, 0);
        check({tag, "_out_of_range"}, oob_cnt, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        bad_hits = 0;
        for (int a = 0; a < NO; a++) if (hits[a] != 1) bad_hits++;
        check({tag, "_addr_not_once"}, bad_hits, 0);
        for (int y = 0; y < OR; y++)
            for (int x = 0; x < OC; x++)
                check($sformatf("%s_dst[%0d]", tag, y * OC + x),
                      dst_mem[y * OC + x], model(y, x));
    endtask

    initial begin
        int cyc;
        int exp_r0 [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
        int exp_r9 [10] = '{10, 10, 10, 10, 11, 11, 11, 11, 12, 12};
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, done, src_rd_en, dst_wr_en,
               src_addr, dst_addr, dst_wr_data}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", busy, 0);

        // job 1: src[i] = i+1
        for (int i = 0; i < NI; i++) src_mem[i] = DW'(i + 1);
        run_job(0, 0, cyc);
        verify_job("j1", cyc);
`ifdef ZERO_FILL_EN
        check("zf_dst0", dst_mem[0], 1);
        check("zf_dst4", dst_mem[4], 2);
        check("zf_dst8", dst_mem[8], 3);
        check("zf_dst30", dst_mem[30], 4);
        check("zf_dst1", dst_mem[1], 0);
`else
        for (int x = 0; x < OC; x++) begin
            check($sformatf("row0_x%0d", x), dst_mem[x], exp_r0[x]);
            check($sformatf("row1_x%0d", x), dst_mem[OC + x], exp_r0[x]);
            check($sformatf("row9_x%0d", x), dst_mem[9 * OC + x], exp_r9[x]);
        end
`endif

        // job 2: random data, stray start at cycle 40
        for (int i = 0; i < NI; i++) src_mem[i] = DW'($urandom);
        run_job(40, 0, cyc);
        verify_job("j2_restart", cyc);

        // job 3: reset at cycle 30 aborts
        for (int i = 0; i < NI; i++) src_mem[i] = DW'($urandom);
        run_job(0, 30, cyc);
        check("j3_rst_cycle", cyc, 30);

        // job 4: fresh job after abort
        for (int i = 0; i < NI; i++) src_mem[i] = DW'($urandom);
        run_job(0, 0, cyc);
        verify_job("j4_after_rst", cyc);

        // straight copy: 3 cycles per element plus done
        for (int i = 0; i < 16; i++) src2[i] = 8'(255 - i);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done2 && cyc < 400);
        check("copy_cycles", cyc, 2 * 16 + 16 + 1);
        check("copy_wr_cnt", wr2_cnt, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("copy_dst[%0d]", i), dst2[i], 255 - i);
        @(negedge clk);
        check("copy_idle", busy2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
